// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end: the buffered entry format
// and the instruction-length increments used to advance the fetch PC.
package fetch_pkg;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        compressed;
   } fetch_entry_t;

   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_0000_1000;
   localparam logic [63:0] INST_LEN_C       = 64'd2;
   localparam logic [63:0] INST_LEN_W       = 64'd4;

   // Compressed instructions carry only inst[15:0]; the cache's upper half is junk.
   function automatic logic [31:0] normalize_inst(input logic compressed, input logic [31:0] raw);
      return compressed ? {16'h0000, raw[15:0]} : raw;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, first-word fall-through head
// and a registered occupancy count from which full/empty are derived.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   output fetch_entry_t             head_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push_ok, pop_ok;

   assign full_o  = (level_q == FULL_LVL);
   assign empty_o = (level_q == '0);
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   // Flush wins over everything; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      push_ok  = push_i & ~full_o & ~flush_i;
      pop_ok   = pop_i & ~empty_o & ~flush_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, captures cache hits into a small FIFO
// and restarts from the execute-stage target on redirect.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [63:0]            pc,
   input  logic                   inst_valid,
   input  logic                   inst_compressed,
   input  logic [31:0]            inst,
   input  logic                   redirect,
   input  logic [63:0]            redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [63:0]            out_pc,
   output logic [31:0]            out_inst,
   output logic                   out_compressed,
   output logic [$clog2(DEPTH):0] level
);

   logic [63:0]  pc_q, pc_d;
   logic         push, pop, full, empty;
   fetch_entry_t push_entry, head;

   // Decode handshake: a transfer happens on a cycle where out_valid and out_ready
   // are both high at the clock edge; out_valid never depends on out_ready, and the
   // head stays stable until it is accepted or a redirect flushes the buffer.
   always_comb begin
      push       = inst_valid & ~full & ~redirect;
      pop        = ~empty & out_ready & ~redirect;
      push_entry = '{pc: pc_q,
                     inst: normalize_inst(inst_compressed, inst),
                     compressed: inst_compressed};
      pc_d       = pc_q;
      if (redirect)
         pc_d = redirect_pc & ~64'd1;
      else if (push)
         pc_d = pc_q + (inst_compressed ? INST_LEN_C : INST_LEN_W);
   end

   // PC only moves at an edge, so the cache sees it stable through a miss.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .level_o     (level),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign pc             = pc_q;
   assign out_valid      = ~empty;
   assign out_pc         = head.pc;
   assign out_inst       = head.inst;
   assign out_compressed = head.compressed;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: driver tasks enqueue expected entries,
// a negedge monitor checks every accepted head against the expected queue.
module tb_fetch_queue;
   import fetch_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = $bits(fetch_entry_t);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc;
   logic        inst_valid, inst_compressed;
   logic [31:0] inst;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_inst;
   logic        out_compressed;
   logic [2:0]  level;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [W-1:0] exp_q[$];
   logic [63:0] cur_pc;
   int          cur_lvl;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(64'h0000_0000_0000_1000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pc              (pc),
      .inst_valid      (inst_valid),
      .inst_compressed (inst_compressed),
      .inst            (inst),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .out_compressed  (out_compressed),
      .level           (level)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every head accepted by decode must match the next expected entry
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n && out_valid && out_ready && !redirect) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got pc 0x%0h inst 0x%0h, expected no entry", out_pc, out_inst);
         end else begin
            e = exp_q.pop_front();
            if ({out_pc, out_inst, out_compressed} !== e) begin
               n_err++;
               $display("FAIL pop_entry: got 0x%0h expected 0x%0h", {out_pc, out_inst, out_compressed}, e);
            end
         end
      end
   end

   // one cycle: apply inputs, record expected push, check hand-computed pc/level after the edge
   task automatic drive(input logic iv, input logic comp, input logic [31:0] ins,
                        input logic ord, input logic redir, input logic [63:0] rpc,
                        input logic [63:0] exp_pc, input int exp_lvl);
      inst_valid      = iv;
      inst_compressed = comp;
      inst            = ins;
      out_ready       = ord;
      redirect        = redir;
      redirect_pc     = rpc;
      if (redir)
         exp_q.delete();
      else if (iv && cur_lvl != DEPTH)
         exp_q.push_back({cur_pc, (comp ? {16'h0000, ins[15:0]} : ins), comp});
      @(posedge clk);
      #1;
      chk("pc", pc, exp_pc);
      chk("level", 64'(level), 64'(exp_lvl));
      chk("out_valid", 64'(out_valid), 64'(exp_lvl != 0));
      cur_pc  = exp_pc;
      cur_lvl = exp_lvl;
   endtask

   initial begin
      rst_n = 1'b0; inst_valid = 1'b0; inst_compressed = 1'b0; inst = '0;
      redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      cur_pc = 64'h1000; cur_lvl = 0;
      #12;
      chk("reset_pc", pc, 64'h1000);
      chk("reset_out_valid", 64'(out_valid), 64'h0);
      chk("reset_level", 64'(level), 64'h0);
      #5 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_pc", pc, 64'h1000);

      // first 32-bit instruction
      drive(1, 0, 32'h0000_0013, 1, 0, 0, 64'h1004, 1);
      chk("first_out_pc", out_pc, 64'h1000);
      chk("first_out_inst", 64'(out_inst), 64'h13);
      chk("first_out_c", 64'(out_compressed), 64'h0);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h1004, 0);

      // mixed 16/32-bit stream from 0x1000, upper half of compressed inst is junk
      drive(0, 0, 32'h0, 1, 1, 64'h1000, 64'h1000, 0);
      drive(1, 1, 32'hdead_4501, 1, 0, 0, 64'h1002, 1);
      drive(1, 0, 32'h00a0_0093, 1, 0, 0, 64'h1006, 1);
      drive(1, 1, 32'h0000_8082, 1, 0, 0, 64'h1008, 1);
      drive(0, 0, 32'hffff_ffff, 1, 0, 0, 64'h1008, 0);

      // fill to DEPTH with decode stalled, then one pop gives one bubble
      drive(0, 0, 32'h0, 1, 1, 64'h1000, 64'h1000, 0);
      drive(1, 0, 32'h1111_1111, 0, 0, 0, 64'h1004, 1);
      drive(1, 0, 32'h1111_2222, 0, 0, 0, 64'h1008, 2);
      drive(1, 0, 32'h1111_3333, 0, 0, 0, 64'h100c, 3);
      drive(1, 0, 32'h1111_4444, 0, 0, 0, 64'h1010, 4);
      drive(1, 0, 32'h1111_5555, 0, 0, 0, 64'h1010, 4);
      drive(1, 1, 32'h1111_6666, 0, 0, 0, 64'h1010, 4);
      drive(1, 0, 32'h0000_0022, 1, 0, 0, 64'h1010, 3);
      drive(1, 0, 32'h0000_0033, 0, 0, 0, 64'h1014, 4);

      // redirect with level 3 and a concurrent push/pop request
      drive(0, 0, 32'h0, 1, 0, 0, 64'h1014, 3);
      drive(1, 0, 32'h0000_0044, 1, 1, 64'h2003, 64'h2002, 0);
      drive(1, 0, 32'h0000_0055, 1, 0, 0, 64'h2006, 1);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h2006, 0);

      // miss for 5 cycles: pc and contents hold
      drive(1, 1, 32'h0000_0001, 0, 0, 0, 64'h2008, 1);
      drive(1, 0, 32'h0000_0066, 0, 0, 0, 64'h200c, 2);
      for (int i = 0; i < 5; i++) drive(0, 0, 32'h0bad_0bad, 0, 0, 0, 64'h200c, 2);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h200c, 1);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h200c, 0);

      // odd target bit cleared, pc wraps past 2^64
      drive(0, 0, 32'h0, 1, 1, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_fffe, 0);
      drive(1, 0, 32'h0000_0077, 1, 0, 0, 64'h2, 1);
      drive(1, 1, 32'h0000_0088, 1, 0, 0, 64'h4, 1);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h4, 0);

      // asynchronous reset between edges
      drive(1, 0, 32'h0000_0099, 0, 0, 0, 64'h8, 1);
      drive(1, 0, 32'h0000_00aa, 0, 0, 0, 64'hc, 2);
      #2;
      rst_n = 1'b0; inst_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("async_rst_pc", pc, 64'h1000);
      chk("async_rst_out_valid", 64'(out_valid), 64'h0);
      chk("async_rst_level", 64'(level), 64'h0);
      exp_q.delete();
      cur_pc = 64'h1000; cur_lvl = 0;
      @(negedge clk); #2 rst_n = 1'b1;
      @(posedge clk); #1;
      drive(1, 0, 32'h0000_0013, 1, 0, 0, 64'h1004, 1);
      drive(0, 0, 32'h0, 1, 0, 0, 64'h1004, 0);

      chk("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
